// File: rtl/ip_access_arbiter.sv
// Round-robin arbiter that shares one IP instance among NREQ requesters,
// running one request/response transaction at a time with a WAIT-state timeout.
//
// state | meaning
// IDLE  | scanning requests from rr_ptr, no transaction in flight
// ISSUE | ip_valid pulse with the latched payload on ip_data
// WAIT  | waiting for ip_done, timer counts WAIT cycles
// RESP  | resp_valid pulse to the granted requester
module ip_access_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic [DATA_W-1:0]         ip_data,
    output logic                      ip_valid,
    input  logic                      ip_done,
    input  logic [DATA_W-1:0]         ip_result,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [TW-1:0]   timer;

    logic            scan_hit;
    logic [GW-1:0]   scan_idx;
    logic [GW-1:0]   scan_cand;
    logic [GW-1:0]   scan_next;
    logic [DATA_W-1:0] scan_payload;

    // Walk downwards so the lowest offset from rr_ptr is the last one to win.
    always_comb begin
        scan_hit  = 1'b0;
        scan_idx  = '0;
        scan_cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_cand = GW'((int'(rr_ptr) + i) % NREQ);
            if (req_valid[scan_cand]) begin
                scan_hit = 1'b1;
                scan_idx = scan_cand;
            end
        end
    end

    assign scan_next    = (scan_idx == GW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
    assign scan_payload = req_data[scan_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            timer      <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            ip_data    <= '0;
            ip_valid   <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            ip_valid   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (scan_hit) begin
                        req_ready <= NREQ'(1) << scan_idx;
                        ip_data   <= scan_payload;
                        ip_valid  <= 1'b1;
                        grant_id  <= scan_idx;
                        rr_ptr    <= scan_next;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A late answer on the final WAIT cycle still counts as success.
                    if (ip_done) begin
                        resp_data  <= ip_result;
                        resp_err   <= 1'b0;
                        resp_valid <= NREQ'(1) << grant_id;
                        state      <= ST_RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        resp_err   <= 1'b1;
                        resp_valid <= NREQ'(1) << grant_id;
                        state      <= ST_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
